// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package serial_add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// 4-bit ripple add slice built from per-bit full adders; purely combinational.
module add4_slice
  import serial_add_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
  output logic              co
);

  logic [NIBBLE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[NIBBLE];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract unit: one 4-bit slice reused over NIB cycles,
// valid/ready handshakes on both sides.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [CW-1:0]     cnt_q;
  logic              accept, last_nib;
  logic [NIBBLE-1:0] x, y, s;
  logic              co, c_msb;

  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt_q == CW'(NIB - 1));

  assign x = a_q[cnt_q*NIBBLE +: NIBBLE];
  assign y = b_q[cnt_q*NIBBLE +: NIBBLE];

  add4_slice u_slice (
    .x  (x),
    .y  (y),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  // Carry into the top bit of the slice, recovered from its sum bit.
  assign c_msb = s[NIBBLE-1] ^ x[NIBBLE-1] ^ y[NIBBLE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ADD;
      end
      ADD: begin
        if (last_nib) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
      b_q <= in_sub ? ~in_b : in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      carry_q <= in_sub ? 1'b1 : in_cin;
      cnt_q   <= '0;
    end else if (state == ADD) begin
      sum_q[cnt_q*NIBBLE +: NIBBLE] <= s;
      carry_q <= co;
      if (last_nib) begin
        cout_q <= co;
        ovf_q  <= co ^ c_msb;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=16: arithmetic, latency,
// backpressure, reset mid-operation and back-to-back throughput.
module tb_serial_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_cin, in_sub;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout, out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency, check the result, then drain it.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int lat;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"},  32'(lat),      32'd4);
    chk({tag, "_sum"},  32'(out_sum),  32'(e_sum));
    chk({tag, "_cout"}, 32'(out_cout), 32'(e_cout));
    chk({tag, "_ovf"},  32'(out_ovf),  32'(e_ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] va [3];
  logic [15:0] vb [3];
  logic        vs [3];
  logic [15:0] ve [3];

  initial begin
    int lat, k, j, last;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(out_sum),   32'd0);
    chk("rst_cout",      32'(out_cout),  32'd0);
    chk("rst_ovf",       32'(out_ovf),   32'd0);
    rst = 1'b0;
    tick();

    run_op("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("cin",     16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_op("sub_brw", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: result held while a competing request is presented.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum",   32'(out_sum),   32'h3333);
      chk("bp_rdy",   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_rdy",   32'(in_ready),  32'd1);

    // Reset two cycles into ADD: in-flight operation must vanish.
    in_a = 16'h1234; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy",   32'(in_ready),  32'd1);
    chk("mid_rst_sum",   32'(out_sum),   32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_no_out", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with both handshakes held high.
    va[0] = 16'h1234; vb[0] = 16'h0F0F; vs[0] = 1'b0; ve[0] = 16'h2143;
    va[1] = 16'hA000; vb[1] = 16'h5000; vs[1] = 1'b1; ve[1] = 16'h5000;
    va[2] = 16'h8000; vb[2] = 16'h8000; vs[2] = 1'b0; ve[2] = 16'h0000;
    k = 0; j = 0; last = 0;
    in_a = va[0]; in_b = vb[0]; in_sub = vs[0]; in_cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && j < 3; cyc++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        chk("b2b_sum", 32'(out_sum), 32'(ve[j]));
        j++;
      end
      tick();
      if (acc) begin
        if (k > 0) chk("b2b_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        k++;
        if (k < 3) begin
          in_a = va[k]; in_b = vb[k]; in_sub = vs[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 32'(j), 32'd3);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; must be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter NIB, default WIDTH/4: number of nibbles processed per operation (derived, not overridden).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and mode on in_a, in_b, in_cin and in_sub are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port in_cin, input, 1 bit: carry-in for an add.
REQ-010 SHALL have port in_sub, input, 1 bit: 1 selects A-B.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_sum, output, WIDTH bits: the sum or difference.
REQ-014 SHALL have port out_cout, output, 1 bit: carry-out of the MSB nibble.
REQ-015 SHALL have port out_ovf, output, 1 bit: signed (two's-complement) overflow.

Function
REQ-016 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; an operation is accepted on a clock edge where in_valid && in_ready.
REQ-018 SHALL, on accept, latch in_a, latch in_b (inverted when in_sub=1), load the carry register with in_sub ? 1 : in_cin, clear the nibble counter and go to ADD.
REQ-019 SHALL, in ADD, add nibble k of the latched A, nibble k of the latched B and the carry register through one 4-bit add slice per cycle, writing sum nibble k and the carry register on each edge, k = 0..NIB-1 LSB-first.
REQ-020 SHALL go from ADD to DONE on the edge that writes nibble NIB-1, so out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
REQ-021 SHALL hold out_valid, out_sum, out_cout and out_ovf stable in DONE until out_valid && out_ready, then go to IDLE.
REQ-022 SHALL compute out_ovf as the carry into the MSB XOR the carry out of the MSB, captured on the final nibble.
REQ-023 SHALL give subtract results modulo 2^WIDTH, with out_cout=1 meaning no borrow (A>=B unsigned).
REQ-024 SHALL ignore in_valid in ADD and DONE, leaving latched operands unchanged.
REQ-025 SHALL require the nibble counter width to be clog2(NIB), with no wrap past NIB-1.
REQ-026 SHALL keep out_valid low in IDLE and ADD, so a consumer asserting out_ready early has no effect.

Reset
REQ-027 SHALL, on rst=1 at any time including mid-ADD or in DONE, immediately force IDLE and clear out_valid, out_sum, out_cout, out_ovf, the counter and the carry register; in_ready SHALL be 1 out of reset.
REQ-028 SHALL discard any in-flight operation on reset and emit no result for it.

Structure
REQ-029 SHALL place the FSM state encoding and the NIBBLE=4 constant in the shared package serial_add_pkg.
REQ-030 SHALL implement the 4-bit add slice as one combinational sub-module, add4_slice (X, Y, Ci -> S, Co), built structurally from per-bit full-adder gates and instantiated once.

Verification
REQ-031 SHALL check add: A=0x1234, B=0x4321, cin=0 -> out_sum=0x5555, cout=0, ovf=0, out_valid 4 edges after accept.
REQ-032 SHALL check carry chain: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; A=0x7FFF, B=0x0001 -> sum=0x8000, ovf=1.
REQ-033 SHALL check subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0; A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-034 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> outputs held, in_ready=0, new in_valid ignored; the result is released on the first out_ready=1.
REQ-035 SHALL check reset mid-op: rst pulsed after 2 ADD cycles -> out_valid=0, in_ready=1 immediately; the next op A=0x0001, B=0x0001 -> sum=0x0002.
REQ-036 SHALL check back-to-back: out_ready held 1, in_valid held 1 -> accepts spaced NIB+2 edges apart, with every result correct.
